// File: rtl/adc_pkg.sv
// Shared definitions for the serial ADC responder slice: FSM state
// encoding, mux-address codes and the default conversion width.
// Optional build macro: ADC_LSB_TRAILER_EN adds the TRAIL state.
package adc_pkg;

   localparam int unsigned ADC_DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      MUX,
      NULL,
      SHIFT,
`ifdef ADC_LSB_TRAILER_EN
      TRAIL,
`endif
      DONE
   } state_t;

   // {SGL,ODD} address codes sent by the master
   localparam logic [1:0] MUX_SGL_CH0 = 2'b10;
   localparam logic [1:0] MUX_SGL_CH1 = 2'b11;
   localparam logic [1:0] MUX_DIF_01  = 2'b00;
   localparam logic [1:0] MUX_DIF_10  = 2'b01;

endpackage

// File: rtl/adc_serial_responder_if.sv
// Serial link between the ADC reader (master) and the responder (slave).
interface adc_serial_responder_if;

   logic cs_n;
   logic sclk;
   logic sdi;
   logic sdo;
   logic sdo_oe;

   modport master (output cs_n, output sclk, output sdi, input sdo, input sdo_oe);
   modport slave  (input cs_n, input sclk, input sdi, output sdo, output sdo_oe);

endinterface

// File: rtl/adc_edge_sync.sv
// Multi-stage synchronizer for an asynchronous input with rise/fall
// pulse detection on the synchronized level.
module adc_edge_sync #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   prev;

   // synchronizer chain plus one-cycle history of its output
   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= {SYNC_STAGES{RST_VAL}};
         prev  <= RST_VAL;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], din};
         prev  <= chain[SYNC_STAGES-1];
      end
   end

   assign level = chain[SYNC_STAGES-1];
   assign rise  = level & ~prev;
   assign fall  = ~level & prev;

endmodule

// File: rtl/adc_serial_responder.sv
// Slave end of the dual-channel serial ADC link: decodes start bit and
// {SGL,ODD} address, then returns a null bit and the selected word MSB-first.
// Optional build macro: ADC_LSB_TRAILER_EN repeats D1..D(DATA_W-1) LSB-first.
module adc_serial_responder
   import adc_pkg::*;
#(
   parameter int unsigned DATA_W      = ADC_DATA_W,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   adc_serial_responder_if.slave link,
   input  logic [DATA_W-1:0]     sample_ch0,
   input  logic [DATA_W-1:0]     sample_ch1,
   output logic [1:0]            mux_sel,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  frame_err
);

   localparam int unsigned CNT_W = $clog2(DATA_W + 1);

   logic              cs_s, sclk_rise, sclk_fall, sdi_s;
   state_t            state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] sel_word;
   logic [DATA_W:0]   diff;
   logic              sgl_bit;
   logic              odd_phase;
   logic              sdo, sdo_oe;

   adc_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
      .clk(clk), .rst(rst), .din(link.cs_n), .level(cs_s), .rise(), .fall()
   );

   adc_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
      .clk(clk), .rst(rst), .din(link.sclk), .level(), .rise(sclk_rise), .fall(sclk_fall)
   );

   adc_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdi_sync (
      .clk(clk), .rst(rst), .din(link.sdi), .level(sdi_s), .rise(), .fall()
   );

   // word selected by {SGL, current sdi}; differences saturate at zero
   always_comb begin
      diff = '0;
      case ({sgl_bit, sdi_s})
         MUX_DIF_01: diff = {1'b0, sample_ch0} - {1'b0, sample_ch1};
         MUX_DIF_10: diff = {1'b0, sample_ch1} - {1'b0, sample_ch0};
         default:    diff = '0;
      endcase
      case ({sgl_bit, sdi_s})
         MUX_SGL_CH0: sel_word = sample_ch0;
         MUX_SGL_CH1: sel_word = sample_ch1;
         default:     sel_word = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
      endcase
   end

   // frame sequencer; shreg is rotated rather than shifted so the word is
   // intact again after the MSB-first pass (needed for the LSB trailer)
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         sgl_bit    <= 1'b0;
         odd_phase  <= 1'b0;
         mux_sel    <= 2'b00;
         sdo        <= 1'b0;
         sdo_oe     <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         if (cs_s && state != IDLE && state != DONE) begin
            state     <= IDLE;
            sdo       <= 1'b0;
            sdo_oe    <= 1'b0;
            frame_err <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  sdo_oe <= 1'b0;
                  sdo    <= 1'b0;
                  if (!cs_s) state <= START;
               end
               START: begin
                  if (sclk_rise && sdi_s) begin
                     state     <= MUX;
                     odd_phase <= 1'b0;
                  end
               end
               MUX: begin
                  if (sclk_rise) begin
                     if (!odd_phase) begin
                        sgl_bit   <= sdi_s;
                        odd_phase <= 1'b1;
                     end else begin
                        mux_sel <= {sgl_bit, sdi_s};
                        shreg   <= sel_word;
                        state   <= NULL;
                     end
                  end
               end
               NULL: begin
                  if (sclk_fall) begin
                     sdo_oe  <= 1'b1;
                     sdo     <= 1'b0;
                     bit_cnt <= '0;
                     state   <= SHIFT;
                  end
               end
               SHIFT: begin
                  if (sclk_fall) begin
                     if (bit_cnt != CNT_W'(DATA_W)) begin
                        sdo     <= shreg[DATA_W-1];
                        shreg   <= {shreg[DATA_W-2:0], shreg[DATA_W-1]};
                        bit_cnt <= bit_cnt + 1'b1;
                     end else begin
`ifdef ADC_LSB_TRAILER_EN
                        sdo     <= shreg[1];
                        shreg   <= {shreg[0], shreg[DATA_W-1:1]};
                        bit_cnt <= CNT_W'(1);
                        state   <= TRAIL;
`else
                        sdo        <= 1'b0;
                        sdo_oe     <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= DONE;
`endif
                     end
                  end
               end
`ifdef ADC_LSB_TRAILER_EN
               TRAIL: begin
                  if (sclk_fall) begin
                     if (bit_cnt != CNT_W'(DATA_W - 1)) begin
                        sdo     <= shreg[1];
                        shreg   <= {shreg[0], shreg[DATA_W-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                     end else begin
                        sdo        <= 1'b0;
                        sdo_oe     <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= DONE;
                     end
                  end
               end
`endif
               DONE: begin
                  sdo    <= 1'b0;
                  sdo_oe <= 1'b0;
                  if (cs_s) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign busy        = (state != IDLE);
   assign link.sdo    = sdo;
   assign link.sdo_oe = sdo_oe;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Directed bench for adc_serial_responder acting as an ADC reader master.
// Honours ADC_LSB_TRAILER_EN when defined for the build.
module tb_adc_serial_responder;

   localparam int HALF = 8;
`ifdef ADC_LSB_TRAILER_EN
   localparam int NRD = 16;
`else
   localparam int NRD = 9;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] sample_ch0, sample_ch1;
   logic [1:0] mux_sel;
   logic       busy, frame_done, frame_err;
   int         vectors = 0;
   int         miscompares = 0;
   int         done_cnt = 0;
   int         err_cnt = 0;

   adc_serial_responder_if bus ();

   adc_serial_responder #(.DATA_W(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .link(bus),
      .sample_ch0(sample_ch0), .sample_ch1(sample_ch1),
      .mux_sel(mux_sel), .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done) done_cnt++;
      if (frame_err) err_cnt++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // null bit, word MSB-first, then D1..D7 when the trailer is built in
   function automatic logic [15:0] stream(input logic [7:0] w);
      logic [15:0] s;
      s = {1'b0, w, 7'b0};
      for (int i = 1; i < 8; i++) s[7-i] = w[i];
      return s >> (16 - NRD);
   endfunction

   task automatic send_bits(input int n, input logic [15:0] bits);
      for (int i = n - 1; i >= 0; i--) begin
         bus.sdi = bits[i];
         wait_clk(HALF);
         bus.sclk = 1'b1;
         wait_clk(HALF);
         bus.sclk = 1'b0;
      end
   endtask

   task automatic read_bits(input int n, output logic [15:0] word, output int oe_bad);
      word = '0;
      oe_bad = 0;
      for (int i = 0; i < n; i++) begin
         wait_clk(HALF);
         word = {word[14:0], bus.sdo};
         if (bus.sdo_oe !== 1'b1) oe_bad++;
         bus.sclk = 1'b1;
         wait_clk(HALF);
         bus.sclk = 1'b0;
      end
   endtask

   task automatic frame(input string tag, input int nh, input logic [15:0] hdr,
                        input logic [7:0] w, input logic [1:0] sel);
      logic [15:0] got;
      int bad;
      done_cnt = 0;
      err_cnt = 0;
      bus.cs_n = 1'b0;
      wait_clk(4);
      send_bits(nh, hdr);
      read_bits(NRD, got, bad);
      wait_clk(4);
      check({tag, "_data"}, got, stream(w));
      check({tag, "_oe_during"}, 16'(bad), 16'd0);
      check({tag, "_oe_after"}, {15'd0, bus.sdo_oe}, 16'd0);
      check({tag, "_done_cnt"}, 16'(done_cnt), 16'd1);
      check({tag, "_err_cnt"}, 16'(err_cnt), 16'd0);
      check({tag, "_mux_sel"}, {14'd0, mux_sel}, {14'd0, sel});
      bus.cs_n = 1'b1;
      wait_clk(6);
      check({tag, "_busy_idle"}, {15'd0, busy}, 16'd0);
   endtask

   initial begin
      logic [15:0] got;
      int bad;
      logic dropped;
      rst = 1'b1;
      bus.cs_n = 1'b1;
      bus.sclk = 1'b0;
      bus.sdi = 1'b0;
      sample_ch0 = 8'h00;
      sample_ch1 = 8'h00;
      wait_clk(4);
      check("rst_sdo", {15'd0, bus.sdo}, 16'd0);
      check("rst_sdo_oe", {15'd0, bus.sdo_oe}, 16'd0);
      check("rst_mux_sel", {14'd0, mux_sel}, 16'd0);
      check("rst_busy", {15'd0, busy}, 16'd0);
      check("rst_pulses", {14'd0, frame_done, frame_err}, 16'd0);
      rst = 1'b0;
      wait_clk(4);
      check("idle_busy", {15'd0, busy}, 16'd0);

      sample_ch0 = 8'hA5;
      sample_ch1 = 8'h3C;
      frame("ch0", 3, 16'b110, 8'hA5, 2'b10);
      frame("ch1", 3, 16'b111, 8'h3C, 2'b11);

      sample_ch0 = 8'h50;
      sample_ch1 = 8'h20;
      frame("dif01", 3, 16'b100, 8'h30, 2'b00);
      sample_ch0 = 8'h10;
      frame("dif01_sat", 3, 16'b100, 8'h00, 2'b00);
      frame("dif10", 3, 16'b101, 8'h10, 2'b01);

      sample_ch0 = 8'hC3;
      frame("lead0", 5, 16'b00110, 8'hC3, 2'b10);

      // abort after the third data bit
      done_cnt = 0;
      err_cnt = 0;
      bus.cs_n = 1'b0;
      wait_clk(4);
      send_bits(3, 16'b111);
      read_bits(4, got, bad);
      check("abort_partial", got, 16'b0_001);
      bus.cs_n = 1'b1;
      dropped = 1'b0;
      for (int i = 0; i < 4 && !dropped; i++) begin
         wait_clk(1);
         if (bus.sdo_oe === 1'b0) dropped = 1'b1;
      end
      check("abort_oe_drop", {15'd0, dropped}, 16'd1);
      wait_clk(10);
      check("abort_err_cnt", 16'(err_cnt), 16'd1);
      check("abort_done_cnt", 16'(done_cnt), 16'd0);
      check("abort_busy", {15'd0, busy}, 16'd0);
      check("abort_mux_sel", {14'd0, mux_sel}, 16'b11);

      sample_ch1 = 8'h96;
      frame("recover", 3, 16'b111, 8'h96, 2'b11);

      // sample change after MUX must not alter the shifted word
      sample_ch0 = 8'h5A;
      done_cnt = 0;
      bus.cs_n = 1'b0;
      wait_clk(4);
      send_bits(3, 16'b110);
      sample_ch0 = 8'hFF;
      read_bits(NRD, got, bad);
      wait_clk(4);
      check("stable_data", got, stream(8'h5A));
      check("stable_done", 16'(done_cnt), 16'd1);
      bus.cs_n = 1'b1;
      wait_clk(6);

      // reset in the middle of a frame
      err_cnt = 0;
      done_cnt = 0;
      bus.cs_n = 1'b0;
      wait_clk(4);
      send_bits(3, 16'b110);
      read_bits(2, got, bad);
      rst = 1'b1;
      wait_clk(1);
      check("midrst_sdo_oe", {15'd0, bus.sdo_oe}, 16'd0);
      check("midrst_busy", {15'd0, busy}, 16'd0);
      check("midrst_mux_sel", {14'd0, mux_sel}, 16'd0);
      check("midrst_pulses", 16'(err_cnt + done_cnt), 16'd0);
      bus.cs_n = 1'b1;
      wait_clk(3);
      rst = 1'b0;
      wait_clk(4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
